mux2_stream_arb: RTL
====================

# mux2_stream_arb

Two-input round-robin packet arbiter that sits directly upstream of the 2:1 mux and drives its select line. It accepts two valid/ready packet streams and grants one whole packet at a time. It presents the granted stream on a single output port and exports the registered select `sel` used by the downstream tri-state 2:1 mux. It also enforces a maximum packet length so a stuck source cannot hold the mux indefinitely.

## Interface
- `WIDTH`, 8: data width of each stream.
- `MAX_BEATS`, 16: maximum beats per packet before forced release, 2..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in0_valid`, `in0_last` in 1 each; `in0_data` in WIDTH; `in0_ready` out 1: stream 0.
- `in1_valid`, `in1_last` in 1 each; `in1_data` in WIDTH; `in1_ready` out 1: stream 1.
- `out_valid`, `out_last` out 1 each; `out_data` out WIDTH; `out_ready` in 1: merged stream.
- `sel` out 1: mux select, 0 = in0, 1 = in1; registered.
- `busy` out 1: high while a packet is granted.
- `err` out 1: one-cycle pulse on forced release.

## Operation
- States are IDLE, GRANT0 and GRANT1, with a 2-bit encoding held in a register.
- **IDLE**
  - All readies and `out_valid` are 0.
  - If exactly one `inN_valid` is high, go to GRANTN.
  - If both are high, grant the input not granted last: `next = ~last_sel`.
  - If neither is high, stay in IDLE.
- **On grant**
  - `sel` and `last_sel` load N.
  - The beat counter clears to 0.
- **GRANTN**
  - Pass-through: `out_valid = inN_valid`, `out_data = inN_data`, `out_last = inN_last`, `inN_ready = out_ready`.
  - The other input's ready is 0.
- **Handshake:** a beat transfers when `out_valid & out_ready`. Each handshake increments the beat counter (8-bit, saturating never reached).
- **Normal end of packet:** a handshake with `out_last=1` returns the FSM to IDLE on the next edge.
- **Forced release:**
  - Trigger: a handshake with `out_last=0` when the counter equals `MAX_BEATS-1`.
  - Response: go to IDLE, pulse `err` for one cycle, and force the next grant to the other input if it is valid.
- **Source stalls:** `inN_valid` low in GRANTN stalls without losing the grant.
- `sel` holds its value in IDLE, so the downstream mux never sees a glitch between packets.
- **Reset mid-packet:** all state clears immediately and the partial packet is abandoned. The source must restart it.

## Timing
- Reset values:
  - state = IDLE, `sel=0`, `last_sel=1` (first contested grant goes to in0), counter = 0.
  - `busy=0`, `err=0`, `out_valid=0`, `in0_ready=0`, `in1_ready=0`.
- Arbitration latency is 1 cycle: valid is seen in IDLE at edge k, and the first beat can transfer in cycle k+1.
- There is one bubble cycle (IDLE) between consecutive packets, which caps throughput at L/(L+1) for L-beat packets.
- Data path is combinational in GRANT states, with 0 cycles of latency through the block. `sel`, state, counter and `err` are registered.
- `busy` is the decoded state (GRANT0 or GRANT1), registered.
- Single-beat packet (`last=1` on the first beat): occupies exactly one GRANT cycle if `out_ready` is high.
- Simultaneous `out_last=1` and counter = `MAX_BEATS-1`: this is a normal end and `err` stays 0.

## Structure
- Shared header `mux2_stream_arb_defs.vh` holds:
  - state encodings `ARB_IDLE=2'd0`, `ARB_G0=2'd1`, `ARB_G1=2'd2`;
  - `SEL_IN0=1'b0`, `SEL_IN1=1'b1`.
- One natural sub-module, `rr_pick2`: a combinational 2-way round-robin picker with inputs `req[1:0]` and `last`, and outputs `gnt_valid` and `gnt_idx`. It is reusable by later arbiters.
- FSM, counter and pass-through stay in the top module.

## Test plan
- After reset, `in1_valid=1` with a 3-beat packet and `out_ready=1`: `sel=1` from cycle 1, 3 beats out in cycles 1–3, IDLE in cycle 4, `err` never set.
- Both inputs valid with 2-beat packets, held continuously:
  - grants alternate in0, in1, in0;
  - `sel` toggles only in IDLE cycles;
  - each packet is followed by exactly one bubble.
- `out_ready` toggled 1,0,1,0 during a 4-beat in0 packet: exactly 4 handshakes, `in1_ready` stays 0, and `data` order is preserved.
- `MAX_BEATS=4` with an in0 packet lacking `last`: after the 4th handshake `err` pulses once, the FSM returns to IDLE, and the pending in1 is granted next.
- `rst_n` asserted low mid-packet in GRANT1: outputs immediately show the reset values, `sel=0`, and the next contested grant goes to in0.
- Single-beat packets on in0 only, back-to-back: throughput is 1 beat per 2 cycles and `sel` stays 0 throughout.

Source files
------------

// File: rtl/mux2_stream_arb_pkg.sv
// Shared encodings for the 2-input stream arbiter: FSM state codes and mux select values.
package mux2_stream_arb_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_G0   = 2'd1;
    localparam logic [1:0] ARB_G1   = 2'd2;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

    function automatic logic is_grant(input logic [1:0] st);
        return (st == ARB_G0) || (st == ARB_G1);
    endfunction

endpackage

// File: rtl/mux2_stream_arb_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes to the side not picked last.
module rr_pick2
    import mux2_stream_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = SEL_IN0;
        unique case (req)
            2'b01:   gnt_idx = SEL_IN0;
            2'b10:   gnt_idx = SEL_IN1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = SEL_IN0;
        endcase
    end

endmodule

// File: rtl/mux2_stream_arb.sv
// Round-robin packet arbiter in front of a 2:1 mux: grants whole packets, drives a registered select,
// and force-releases a packet that exceeds MAX_BEATS.
module mux2_stream_arb
    import mux2_stream_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic             in0_last,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic             in1_last,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic             out_last,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy,
    output logic             err
);

    localparam logic [7:0] CNT_MAX = 8'(MAX_BEATS - 1);

    logic [1:0] state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_sel_q, last_sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       pick_valid, pick_idx;
    logic       hs;

    rr_pick2 u_pick (
        .req       ({in1_valid, in0_valid}),
        .last      (last_sel_q),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // Zero-latency pass-through of the granted stream; nothing is presented while idle.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        case (state_q)
            ARB_G0: begin
                out_valid = in0_valid;
                out_last  = in0_last;
                out_data  = in0_data;
                in0_ready = out_ready;
            end
            ARB_G1: begin
                out_valid = in1_valid;
                out_last  = in1_last;
                out_data  = in1_data;
                in1_ready = out_ready;
            end
            default: ;
        endcase
        hs = out_valid & out_ready;
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d    = (pick_idx == SEL_IN1) ? ARB_G1 : ARB_G0;
                    sel_d      = pick_idx;
                    last_sel_d = pick_idx;
                    cnt_d      = 8'd0;
                end
            end
            ARB_G0, ARB_G1: begin
                if (hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (out_last) begin
                        state_d = ARB_IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        // last_sel already names this input, so a pending peer wins the next tie.
                        state_d = ARB_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        busy_d = is_grant(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            sel_q      <= SEL_IN0;
            last_sel_q <= SEL_IN1;
            cnt_q      <= 8'd0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign sel  = sel_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule
